// File: rtl/uart_pkg.sv
// Shared definitions for the SOL-side UART receiver.
// State encoding and oversampling constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_BITS  = 8;

    localparam logic [3:0] MID_CNT  = 4'(MID_SAMPLE);
    localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_sol_rx_if.sv
// Serial input and received-byte outputs of the SOL receiver.
// master drives the line, slave is the receiver.
interface uart_sol_rx_if;
    import uart_pkg::*;

    logic                 rxd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rxd,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rxd,
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy
    );

endinterface

// File: rtl/uart_baud_tick.sv
// 16x oversample tick generator.
// restart re-phases the count to the detected start edge.
module uart_baud_tick #(
    parameter int CLK_DIV = 14
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam logic [7:0] TOP = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q;

    // Free-running prescaler, wraps at CLK_DIV-1
    always_ff @(posedge clk) begin
        if (!reset || restart) begin
            cnt_q <= '0;
        end else if (cnt_q == TOP) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign tick = (cnt_q == TOP);

endmodule

// File: rtl/uart_sol_rx.sv
// 8N1 UART receiver on the CPLD side of the SOL path.
// Mid-bit sampling on a 16x tick; BREAK absorbs a held-low line.
module uart_sol_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV     = 14,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    uart_sol_rx_if.slave  rx_if
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   tick;
    logic                   restart;

    state_t                 state_q, state_d;
    logic [3:0]             samp_q, samp_d;
    logic [2:0]             bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;

    // Bring the asynchronous line into the clk domain
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_if.rxd};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // Receiver state, counters, shifter and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            samp_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Frame sequencing: start check, mid-bit data sampling, stop check
    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        restart = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    samp_d  = '0;
                    restart = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (samp_q == MID_CNT) begin
                        samp_d = '0;
                        if (!rxs) begin
                            state_d = DATA;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        samp_d = samp_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (samp_q == LAST_CNT) begin
                        samp_d  = '0;
                        shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                        if (bit_q == LAST_BIT) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        samp_d = samp_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (samp_q == LAST_CNT) begin
                        samp_d = '0;
                        if (rxs) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        samp_d = samp_q + 4'd1;
                    end
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_if.rx_data   = data_q;
    assign rx_if.rx_valid  = valid_q;
    assign rx_if.frame_err = ferr_q;
    assign rx_if.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_sol_rx.sv
// Bench for uart_sol_rx: serial frames in, byte stream checked
// against a queue of bytes the bench itself transmitted.
module tb_uart_sol_rx;

    localparam int CLK_DIV = 14;
    localparam int BIT     = CLK_DIV * 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #20 clk = ~clk;

    uart_sol_rx_if u_if ();

    uart_sol_rx #(
        .CLK_DIV     (CLK_DIV),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx_if (u_if.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_good;
    int         ferr_cnt  = 0;
    int         proto_err = 0;
    logic       busy_seen = 1'b0;
    logic       prev_v    = 1'b0;
    logic       prev_f    = 1'b0;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (u_if.rx_valid === 1'b1) got_q.push_back(u_if.rx_data);
            if (u_if.frame_err === 1'b1) ferr_cnt++;
            if (u_if.busy === 1'b1) busy_seen = 1'b1;
            if ((u_if.rx_valid && u_if.frame_err) ||
                ((u_if.rx_valid || u_if.frame_err) && (prev_v || prev_f)))
                proto_err++;
        end
        prev_v = u_if.rx_valid;
        prev_f = u_if.frame_err;
    end

    task automatic send_byte(input logic [7:0] b, input int per,
                             input logic stop_bit);
        u_if.rxd = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            u_if.rxd = b[i];
            repeat (per) @(negedge clk);
        end
        u_if.rxd = stop_bit;
        repeat (per) @(negedge clk);
    endtask

    task automatic clear_obs();
        got_q.delete();
        exp_q.delete();
        ferr_cnt  = 0;
        busy_seen = 1'b0;
    endtask

    task automatic test_reset();
        u_if.rxd = 1'b1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        checks += 4;
        if (u_if.rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_data got %h exp 00", u_if.rx_data);
        end
        if (u_if.rx_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b exp 0", u_if.rx_valid);
        end
        if (u_if.frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_ferr got %b exp 0", u_if.frame_err);
        end
        if (u_if.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b exp 0", u_if.busy);
        end
        clear_obs();
        repeat (20 * BIT) @(negedge clk);
        checks += 3;
        if (got_q.size() != 0) begin
            errors++; $display("FAIL idle_valid got %0d exp 0", got_q.size());
        end
        if (ferr_cnt != 0) begin
            errors++; $display("FAIL idle_ferr got %0d exp 0", ferr_cnt);
        end
        if (busy_seen !== 1'b0) begin
            errors++; $display("FAIL idle_busy got %b exp 0", busy_seen);
        end
        last_good = 8'h00;
    endtask

    task automatic test_single();
        clear_obs();
        send_byte(8'hA5, BIT, 1'b1);
        repeat (BIT) @(negedge clk);
        checks += 4;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL single_count got %0d exp 1", got_q.size());
        end else if (got_q[0] !== 8'hA5) begin
            errors++; $display("FAIL single_data got %h exp a5", got_q[0]);
        end
        if (ferr_cnt != 0) begin
            errors++; $display("FAIL single_ferr got %0d exp 0", ferr_cnt);
        end
        if (u_if.rx_data !== 8'hA5) begin
            errors++; $display("FAIL single_hold got %h exp a5", u_if.rx_data);
        end
        if (u_if.busy !== 1'b0) begin
            errors++; $display("FAIL single_busy got %b exp 0", u_if.busy);
        end
        last_good = 8'hA5;
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [3];
        seq[0] = 8'h55;
        seq[1] = 8'h00;
        seq[2] = 8'hFF;
        clear_obs();
        for (int i = 0; i < 3; i++) send_byte(seq[i], BIT, 1'b1);
        repeat (BIT) @(negedge clk);
        checks += 2;
        if (got_q.size() != 3) begin
            errors++; $display("FAIL b2b_count got %0d exp 3", got_q.size());
        end
        if (ferr_cnt != 0) begin
            errors++; $display("FAIL b2b_ferr got %0d exp 0", ferr_cnt);
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== seq[i]) begin
                errors++;
                $display("FAIL b2b_data%0d got %h exp %h", i, got_q[i], seq[i]);
            end
        end
        last_good = 8'hFF;
    endtask

    task automatic test_random();
        logic [7:0] b;
        int per;
        clear_obs();
        for (int i = 0; i < 6; i++) begin
            b   = 8'($urandom);
            per = $urandom_range(230, 218);
            exp_q.push_back(b);
            send_byte(b, per, 1'b1);
            repeat ($urandom_range(BIT, 0)) @(negedge clk);
        end
        repeat (BIT) @(negedge clk);
        checks += 2;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        if (ferr_cnt != 0) begin
            errors++; $display("FAIL rand_ferr got %0d exp 0", ferr_cnt);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_data%0d got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
        last_good = exp_q[exp_q.size() - 1];
    endtask

    task automatic test_glitch();
        clear_obs();
        u_if.rxd = 1'b0;
        repeat (3) @(negedge clk);
        u_if.rxd = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (u_if.busy !== 1'b1) begin
            errors++; $display("FAIL glitch_seen got %b exp 1", u_if.busy);
        end
        repeat (8 * CLK_DIV + 8) @(negedge clk);
        checks += 3;
        if (u_if.busy !== 1'b0) begin
            errors++; $display("FAIL glitch_busy got %b exp 0", u_if.busy);
        end
        if (got_q.size() != 0) begin
            errors++; $display("FAIL glitch_valid got %0d exp 0", got_q.size());
        end
        if (ferr_cnt != 0) begin
            errors++; $display("FAIL glitch_ferr got %0d exp 0", ferr_cnt);
        end
        repeat (BIT) @(negedge clk);
    endtask

    task automatic test_break();
        clear_obs();
        send_byte(8'h3C, BIT, 1'b0);
        repeat (30 * BIT) @(negedge clk);
        u_if.rxd = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        checks += 4;
        if (ferr_cnt != 1) begin
            errors++; $display("FAIL break_ferr got %0d exp 1", ferr_cnt);
        end
        if (got_q.size() != 0) begin
            errors++; $display("FAIL break_valid got %0d exp 0", got_q.size());
        end
        if (u_if.rx_data !== last_good) begin
            errors++;
            $display("FAIL break_hold got %h exp %h", u_if.rx_data, last_good);
        end
        if (u_if.busy !== 1'b0) begin
            errors++; $display("FAIL break_busy got %b exp 0", u_if.busy);
        end
        send_byte(8'h81, BIT, 1'b1);
        repeat (BIT) @(negedge clk);
        checks += 2;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL after_break_count got %0d exp 1", got_q.size());
        end else if (got_q[0] !== 8'h81) begin
            errors++; $display("FAIL after_break_data got %h exp 81", got_q[0]);
        end
        if (ferr_cnt != 1) begin
            errors++; $display("FAIL after_break_ferr got %0d exp 1", ferr_cnt);
        end
        last_good = 8'h81;
    endtask

    task automatic test_reset_mid();
        clear_obs();
        fork
            send_byte(8'hF0, BIT, 1'b1);
            begin
                repeat (5 * BIT + BIT / 2) @(negedge clk);
                reset = 1'b0;
            end
        join
        checks += 3;
        if (u_if.busy !== 1'b0) begin
            errors++; $display("FAIL midrst_busy got %b exp 0", u_if.busy);
        end
        if (u_if.rx_data !== 8'h00) begin
            errors++; $display("FAIL midrst_data got %h exp 00", u_if.rx_data);
        end
        if (u_if.rx_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_valid got %b exp 0", u_if.rx_valid);
        end
        reset = 1'b1;
        repeat (BIT) @(negedge clk);
        send_byte(8'h12, BIT, 1'b1);
        repeat (BIT) @(negedge clk);
        checks += 2;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL midrst_count got %0d exp 1", got_q.size());
        end else if (got_q[0] !== 8'h12) begin
            errors++; $display("FAIL midrst_next got %h exp 12", got_q[0]);
        end
        if (ferr_cnt != 0) begin
            errors++; $display("FAIL midrst_ferr got %0d exp 0", ferr_cnt);
        end
        last_good = 8'h12;
    endtask

    task automatic test_baud_tol();
        int pers [2];
        pers[0] = 231;
        pers[1] = 217;
        for (int k = 0; k < 2; k++) begin
            clear_obs();
            send_byte(8'hC3, pers[k], 1'b1);
            repeat (BIT) @(negedge clk);
            checks += 2;
            if (got_q.size() != 1) begin
                errors++;
                $display("FAIL baud%0d_count got %0d exp 1", pers[k], got_q.size());
            end else if (got_q[0] !== 8'hC3) begin
                errors++;
                $display("FAIL baud%0d_data got %h exp c3", pers[k], got_q[0]);
            end
            if (ferr_cnt != 0) begin
                errors++;
                $display("FAIL baud%0d_ferr got %0d exp 0", pers[k], ferr_cnt);
            end
        end
        last_good = 8'hC3;
    endtask

    initial begin
        u_if.rxd  = 1'b1;
        last_good = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_glitch();
        test_break();
        test_reset_mid();
        test_baud_tol();
        checks++;
        if (proto_err != 0) begin
            errors++; $display("FAIL pulse_rules got %0d exp 0", proto_err);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
